btn_counter_ctrl: RTL and testbench

Synchronous controller that sequences the team's N-bit up/down counter from three raw active-low push-buttons (increment, decrement, reset-to-max). Per button: 2-flop synchroniser, debounce FSM, press detection and optional auto-repeat. A fixed-priority arbiter then issues at most one command per clock to an internal saturating counter, which is exposed on count. Sits between the board buttons and the display/LED logic; replaces direct button-edge clocking of the counter.

---
 rtl/btn_counter_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_btn_counter_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_counter_ctrl.sv
// Push-button front end for a saturating up/down counter: per-button synchroniser,
// debounce FSM with optional auto-repeat, pending flags and a fixed-priority arbiter.

module btn_debounce #(
    parameter int DEB_CYCLES    = 50000,
    parameter int REPEAT_CYCLES = 0,
    parameter int CNT_W         = 17,
    parameter bit CAN_REPEAT    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic press_o
);
    // state        | meaning
    // RELEASED     | button stable released, waiting for a low sample
    // PRESS_WAIT   | low seen, counting stable low samples
    // PRESSED      | press accepted; repeat timer runs if enabled
    // RELEASE_WAIT | high seen, counting stable high samples
    typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    localparam logic [CNT_W-1:0] DEB_LOAD = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LOAD = CNT_W'(REPEAT_CYCLES > 0 ? REPEAT_CYCLES - 1 : 0);
    localparam bit               REP_EN   = CAN_REPEAT && (REPEAT_CYCLES > 0);

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] deb_tmr_q, deb_tmr_d;
    logic [CNT_W-1:0] rep_tmr_q, rep_tmr_d;
    logic             deb_done, rep_done;

    assign deb_done = (deb_tmr_q == '0);
    assign rep_done = REP_EN && (rep_tmr_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= RELEASED;
            deb_tmr_q <= '0;
            rep_tmr_q <= '0;
        end else begin
            sync1_q   <= btn_raw_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            deb_tmr_q <= deb_tmr_d;
            rep_tmr_q <= rep_tmr_d;
        end
    end

    // Timers are down-counters loaded with period-1; terminal count is zero.
    always_comb begin
        state_d   = state_q;
        deb_tmr_d = deb_tmr_q;
        rep_tmr_d = rep_tmr_q;
        case (state_q)
            RELEASED: begin
                if (!sync2_q) begin
                    state_d   = PRESS_WAIT;
                    deb_tmr_d = DEB_LOAD;
                end
            end
            PRESS_WAIT: begin
                if (sync2_q) begin
                    state_d = RELEASED;
                end else if (deb_done) begin
                    state_d   = PRESSED;
                    rep_tmr_d = REP_LOAD;
                end else begin
                    deb_tmr_d = deb_tmr_q - 1'b1;
                end
            end
            PRESSED: begin
                if (sync2_q) begin
                    state_d   = RELEASE_WAIT;
                    deb_tmr_d = DEB_LOAD;
                end else if (REP_EN) begin
                    rep_tmr_d = rep_done ? REP_LOAD : rep_tmr_q - 1'b1;
                end
            end
            RELEASE_WAIT: begin
                // bounce back to PRESSED leaves the repeat phase untouched
                if (!sync2_q) begin
                    state_d = PRESSED;
                end else if (deb_done) begin
                    state_d = RELEASED;
                end else begin
                    deb_tmr_d = deb_tmr_q - 1'b1;
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    always_comb begin
        press_o = 1'b0;
        case (state_q)
            PRESS_WAIT: press_o = !sync2_q && deb_done;
            PRESSED:    press_o = !sync2_q && rep_done;
            default:    press_o = 1'b0;
        endcase
    end
endmodule

module btn_counter_ctrl #(
    parameter int N             = 6,
    parameter int DEB_CYCLES    = 50000,
    parameter int REPEAT_CYCLES = 0,
    parameter int CNT_W         = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         btn_increment,
    input  logic         btn_decrement,
    input  logic         btn_reset,
    output logic [N-1:0] count,
    output logic         cmd_inc,
    output logic         cmd_dec,
    output logic         cmd_max,
    output logic         sat
);
    localparam logic [N-1:0] CNT_MAX = '1;

    logic         press_inc, press_dec, press_max;
    logic         pend_inc_q, pend_inc_d, pend_dec_q, pend_dec_d, pend_max_q, pend_max_d;
    logic         grant_inc, grant_dec, grant_max;
    logic [N-1:0] count_q, count_d;
    logic         cmd_inc_q, cmd_inc_d, cmd_dec_q, cmd_dec_d, cmd_max_q, cmd_max_d;
    logic         sat_q, sat_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .CNT_W(CNT_W),
                   .CAN_REPEAT(1'b1))
        u_deb_inc (.clk(clk), .rst_n(rst_n), .btn_raw_i(btn_increment), .press_o(press_inc));

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .CNT_W(CNT_W),
                   .CAN_REPEAT(1'b1))
        u_deb_dec (.clk(clk), .rst_n(rst_n), .btn_raw_i(btn_decrement), .press_o(press_dec));

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .CNT_W(CNT_W),
                   .CAN_REPEAT(1'b0))
        u_deb_max (.clk(clk), .rst_n(rst_n), .btn_raw_i(btn_reset), .press_o(press_max));

    // Max outranks everything and discards any inc/dec waiting behind it.
    always_comb begin
        grant_max = pend_max_q;
        grant_dec = pend_dec_q && !pend_max_q;
        grant_inc = pend_inc_q && !pend_dec_q && !pend_max_q;

        pend_max_d = (pend_max_q && !grant_max) || press_max;
        pend_dec_d = (pend_dec_q && !grant_dec && !grant_max) || press_dec;
        pend_inc_d = (pend_inc_q && !grant_inc && !grant_max) || press_inc;

        count_d   = count_q;
        cmd_inc_d = 1'b0;
        cmd_dec_d = 1'b0;
        cmd_max_d = 1'b0;
        sat_d     = 1'b0;
        if (grant_max) begin
            count_d   = CNT_MAX;
            cmd_max_d = 1'b1;
        end else if (grant_dec) begin
            cmd_dec_d = 1'b1;
            if (count_q != '0) count_d = count_q - 1'b1;
            else               sat_d   = 1'b1;
        end else if (grant_inc) begin
            cmd_inc_d = 1'b1;
            if (count_q != CNT_MAX) count_d = count_q + 1'b1;
            else                    sat_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_inc_q <= 1'b0;
            pend_dec_q <= 1'b0;
            pend_max_q <= 1'b0;
            count_q    <= CNT_MAX;
            cmd_inc_q  <= 1'b0;
            cmd_dec_q  <= 1'b0;
            cmd_max_q  <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            pend_inc_q <= pend_inc_d;
            pend_dec_q <= pend_dec_d;
            pend_max_q <= pend_max_d;
            count_q    <= count_d;
            cmd_inc_q  <= cmd_inc_d;
            cmd_dec_q  <= cmd_dec_d;
            cmd_max_q  <= cmd_max_d;
            sat_q      <= sat_d;
        end
    end

    assign count   = count_q;
    assign cmd_inc = cmd_inc_q;
    assign cmd_dec = cmd_dec_q;
    assign cmd_max = cmd_max_q;
    assign sat     = sat_q;
endmodule

// File: tb/tb_btn_counter_ctrl.sv
// Bench for btn_counter_ctrl: directed scenarios plus random button traffic
// checked cycle by cycle against a run-length debounce / saturating-counter model.

module tb_btn_counter_ctrl;
    localparam int N     = 3;
    localparam int DEB   = 4;
    localparam int REP   = 8;
    localparam int MAXV  = 7;
    localparam int I_INC = 0;
    localparam int I_DEC = 1;
    localparam int I_MAX = 2;
    localparam int I_SAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst0 = 1'b0, inc0 = 1'b1, dec0 = 1'b1, max0 = 1'b1;
    logic [N-1:0] count0;
    logic         ci0, cd0, cm0, sat0;
    logic         rst1 = 1'b0, inc1 = 1'b1, dec1 = 1'b1, max1 = 1'b1;
    logic [N-1:0] count1;
    logic         ci1, cd1, cm1, sat1;

    btn_counter_ctrl #(.N(N), .DEB_CYCLES(DEB), .REPEAT_CYCLES(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst0), .btn_increment(inc0), .btn_decrement(dec0),
        .btn_reset(max0), .count(count0), .cmd_inc(ci0), .cmd_dec(cd0),
        .cmd_max(cm0), .sat(sat0));

    btn_counter_ctrl #(.N(N), .DEB_CYCLES(DEB), .REPEAT_CYCLES(REP), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst1), .btn_increment(inc1), .btn_decrement(dec1),
        .btn_reset(max1), .count(count1), .cmd_inc(ci1), .cmd_dec(cd1),
        .cmd_max(cm1), .sat(sat1));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model for dut0: a button level flips after DEB+1 consecutive
    // synchronised samples disagree with it; each flip to pressed queues one command.
    int m_count;
    bit m_ci, m_cd, m_cm, m_sat;
    bit m_pend[3];
    bit m_deb[3];
    int m_run[3];
    bit m_d1[3], m_d2[3];

    int cnt0[4], first0[4], cnt1[4];
    int inc1_t[$];
    int tick_no;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = MAXV;
        {m_ci, m_cd, m_cm, m_sat} = 4'b0;
        for (int b = 0; b < 3; b++) begin
            m_pend[b] = 1'b0;
            m_deb[b]  = 1'b1;
            m_run[b]  = 0;
            m_d1[b]   = 1'b1;
            m_d2[b]   = 1'b1;
        end
    endtask

    task automatic model_step();
        bit raw[3];
        bit s;
        if (!rst0) begin
            model_reset();
            return;
        end
        raw = '{inc0, dec0, max0};
        {m_ci, m_cd, m_cm, m_sat} = 4'b0;
        if (m_pend[I_MAX]) begin
            m_count = MAXV;
            m_cm    = 1'b1;
            m_pend  = '{1'b0, 1'b0, 1'b0};
        end else if (m_pend[I_DEC]) begin
            m_cd = 1'b1;
            m_pend[I_DEC] = 1'b0;
            if (m_count > 0) m_count--;
            else             m_sat = 1'b1;
        end else if (m_pend[I_INC]) begin
            m_ci = 1'b1;
            m_pend[I_INC] = 1'b0;
            if (m_count < MAXV) m_count++;
            else                m_sat = 1'b1;
        end
        for (int b = 0; b < 3; b++) begin
            s = m_d2[b];
            m_d2[b] = m_d1[b];
            m_d1[b] = raw[b];
            if (s != m_deb[b]) m_run[b]++;
            else               m_run[b] = 0;
            if (m_run[b] == DEB + 1) begin
                m_deb[b] = s;
                m_run[b] = 0;
                if (!s) m_pend[b] = 1'b1;
            end
        end
    endtask

    task automatic clear_watch();
        for (int i = 0; i < 4; i++) begin
            cnt0[i]   = 0;
            first0[i] = 0;
            cnt1[i]   = 0;
        end
        inc1_t.delete();
        tick_no = 0;
    endtask

    task automatic tick();
        logic [3:0] s0, s1;
        @(posedge clk);
        model_step();
        #1;
        tick_no++;
        chk("model", 32'({count0, ci0, cd0, cm0, sat0}),
            32'({3'(m_count), m_ci, m_cd, m_cm, m_sat}));
        s0 = {sat0, cm0, cd0, ci0};
        s1 = {sat1, cm1, cd1, ci1};
        for (int i = 0; i < 4; i++) begin
            if (s0[i]) begin
                cnt0[i]++;
                if (first0[i] == 0) first0[i] = tick_no;
            end
            if (s1[i]) cnt1[i]++;
        end
        if (ci1) inc1_t.push_back(tick_no);
    endtask

    task automatic press0(input logic [2:0] mask, input int hold, input int idle);
        inc0 = !mask[0];
        dec0 = !mask[1];
        max0 = !mask[2];
        repeat (hold) tick();
        {inc0, dec0, max0} = 3'b111;
        repeat (idle) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  hold[3];
        bit  lv[3];

        model_reset();
        clear_watch();
        repeat (3) tick();
        chk("rst_count", 32'(count0), MAXV);
        chk("rst_strobes", 32'({ci0, cd0, cm0, sat0}), 0);
        chk("rst_count_rep", 32'(count1), MAXV);
        rst0 = 1'b1;
        rst1 = 1'b1;
        repeat (3) tick();

        // single held decrement: one command, 8 cycles after the falling edge
        clear_watch();
        dec0 = 1'b0;
        repeat (20) tick();
        dec0 = 1'b1;
        repeat (20) tick();
        chk("t1_ndec", cnt0[I_DEC], 1);
        chk("t1_latency", first0[I_DEC], 8);
        chk("t1_count", 32'(count0), 6);

        // glitch shorter than debounce, then inc to max and saturate
        clear_watch();
        inc0 = 1'b0;
        repeat (3) tick();
        inc0 = 1'b1;
        repeat (20) tick();
        chk("t2_glitch_ninc", cnt0[I_INC], 0);
        chk("t2_glitch_count", 32'(count0), 6);
        clear_watch();
        press0(3'b001, 10, 20);
        chk("t2_inc_count", 32'(count0), 7);
        chk("t2_inc_nsat", cnt0[I_SAT], 0);
        clear_watch();
        press0(3'b001, 10, 20);
        chk("t2_sat_count", 32'(count0), 7);
        chk("t2_sat_ninc", cnt0[I_INC], 1);
        chk("t2_sat_nsat", cnt0[I_SAT], 1);

        // eight decrements from 7, no wrap below 0
        for (int i = 0; i < 8; i++) begin
            clear_watch();
            press0(3'b010, 10, 20);
            chk("t3_count", 32'(count0), (i < 7) ? 6 - i : 0);
            chk("t3_sat", cnt0[I_SAT], (i == 7) ? 1 : 0);
        end

        // simultaneous presses: max discards inc/dec; dec before inc
        press0(3'b001, 10, 20);
        press0(3'b001, 10, 20);
        chk("t4_pre_count", 32'(count0), 2);
        clear_watch();
        press0(3'b111, 10, 20);
        chk("t4_nmax", cnt0[I_MAX], 1);
        chk("t4_nincdec", cnt0[I_INC] + cnt0[I_DEC], 0);
        chk("t4_max_count", 32'(count0), 7);
        clear_watch();
        press0(3'b011, 10, 20);
        chk("t4_ndec", cnt0[I_DEC], 1);
        chk("t4_ninc", cnt0[I_INC], 1);
        chk("t4_dec_time", first0[I_DEC], 8);
        chk("t4_inc_time", first0[I_INC], 9);
        chk("t4_count", 32'(count0), 7);

        // reset with pend_inc set and decrement mid-debounce
        press0(3'b010, 10, 20);
        press0(3'b010, 10, 20);
        chk("t6_pre_count", 32'(count0), 5);
        inc0 = 1'b0;
        repeat (3) tick();
        dec0 = 1'b0;
        repeat (4) tick();
        #2;
        rst0 = 1'b0;
        #1;
        chk("t6_rst_count", 32'(count0), 7);
        chk("t6_rst_strobes", 32'({ci0, cd0, cm0, sat0}), 0);
        inc0 = 1'b1;
        dec0 = 1'b1;
        repeat (2) tick();
        rst0 = 1'b1;
        clear_watch();
        repeat (30) tick();
        chk("t6_no_stale", cnt0[I_INC] + cnt0[I_DEC] + cnt0[I_MAX] + cnt0[I_SAT], 0);
        chk("t6_count", 32'(count0), 7);

        // auto-repeat on the REPEAT_CYCLES=8 instance
        clear_watch();
        dec1 = 1'b0;
        repeat (58) tick();
        dec1 = 1'b1;
        repeat (20) tick();
        chk("t5_ndec", cnt1[I_DEC], 7);
        chk("t5_zero", 32'(count1), 0);
        clear_watch();
        inc1 = 1'b0;
        repeat (40) tick();
        inc1 = 1'b1;
        repeat (20) tick();
        chk("t5_ninc", cnt1[I_INC], 5);
        for (int j = 0; j < 5; j++) begin
            if (j < inc1_t.size()) chk("t5_rep_time", inc1_t[j], 8 + 8 * j);
        end
        chk("t5_inc_count", 32'(count1), 5);
        chk("t5_nsat", cnt1[I_SAT], 0);
        clear_watch();
        max1 = 1'b0;
        repeat (40) tick();
        max1 = 1'b1;
        repeat (20) tick();
        chk("t5_nmax", cnt1[I_MAX], 1);
        chk("t5_max_count", 32'(count1), 7);

        // random button traffic on dut0 against the model
        for (int b = 0; b < 3; b++) begin
            hold[b] = 0;
            lv[b]   = 1'b1;
        end
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    lv[b]   = !lv[b];
                    hold[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                          : int'($urandom_range(5, 16));
                end
                hold[b]--;
            end
            inc0 = lv[0];
            dec0 = lv[1];
            max0 = (c % 4 == 0) ? lv[2] : max0;
            tick();
        end
        {inc0, dec0, max0} = 3'b111;
        repeat (30) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
